// File: rtl/block_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : block_transfer_sequencer
// Description : Multi-cycle LDM/STM sequencer. Captures a register list and
//               base address at start, then issues one memory beat per set
//               bit (lowest register first, ascending addresses). Stores read
//               the register file through read_rm/rm_data; loads write
//               through rd_we/write_rd/rd_in, or through pc_we/pc_in for the
//               PC. Optional base-register writeback in the WB state.
// Ports       : clk, reset (async, active-low)
//               start, is_load, up, pre, writeback, base_reg, base_addr,
//               reg_list                      - request from decode
//               mem_req, mem_we, mem_addr, mem_wdata, mem_ready, mem_rdata
//                                             - memory beat interface
//               read_rm, rm_data              - register file read port
//               rd_we, write_rd, rd_in        - register file write port
//               pc_we, pc_in                  - PC write port
//               busy, done                    - status to the core
// Revision    : 1.0 - initial release
// ============================================================================
module block_transfer_sequencer #(
    parameter int WORD_SIZE  = 32,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_load,
    input  logic                  up,
    input  logic                  pre,
    input  logic                  writeback,
    input  logic [ADDR_WIDTH-1:0] base_reg,
    input  logic [WORD_SIZE-1:0]  base_addr,
    input  logic [NUM_REGS-1:0]   reg_list,
    input  logic                  mem_ready,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    input  logic [WORD_SIZE-1:0]  rm_data,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic [ADDR_WIDTH-1:0] read_rm,
    output logic                  rd_we,
    output logic [ADDR_WIDTH-1:0] write_rd,
    output logic [WORD_SIZE-1:0]  rd_in,
    output logic                  pc_we,
    output logic [WORD_SIZE-1:0]  pc_in
);

    // Count must represent 0..NUM_REGS inclusive.
    localparam int c_cnt_w = $clog2(NUM_REGS + 1);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_xfer = 2'd1;
    localparam logic [1:0] c_s_wb   = 2'd2;
    localparam logic [1:0] c_s_done = 2'd3;

    localparam logic [WORD_SIZE-1:0]  c_four   = WORD_SIZE'(4);
    localparam logic [ADDR_WIDTH-1:0] c_pc_idx = ADDR_WIDTH'(NUM_REGS - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [NUM_REGS-1:0]   r_remaining;
    logic [WORD_SIZE-1:0]  r_addr;
    logic [WORD_SIZE-1:0]  r_final_addr;
    logic                  r_is_load;
    logic                  r_wb_en;
    logic [ADDR_WIDTH-1:0] r_base_reg;

    logic [c_cnt_w-1:0]    w_count;
    logic [WORD_SIZE-1:0]  w_span;
    logic [WORD_SIZE-1:0]  w_start_addr;
    logic [WORD_SIZE-1:0]  w_final_addr;
    logic                  w_wb_en;
    logic [ADDR_WIDTH-1:0] w_cur_idx;
    logic [NUM_REGS-1:0]   w_rem_next;
    logic                  w_last;
    logic                  w_accept;

    // ------------------------------------------------------------------
    // Start-time address computation
    // ------------------------------------------------------------------
    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_count = w_count + c_cnt_w'(reg_list[i]);
        end
    end

    assign w_span = WORD_SIZE'({w_count, 2'b00});

    // Beats always walk upward, so decrement modes start at the bottom of
    // the block: DB = base-4N, DA = base-4N+4.
    always_comb begin
        w_start_addr = base_addr;
        case ({up, pre})
            2'b10:   w_start_addr = base_addr;
            2'b11:   w_start_addr = base_addr + c_four;
            2'b00:   w_start_addr = base_addr - w_span + c_four;
            default: w_start_addr = base_addr - w_span;
        endcase
    end

    assign w_final_addr = up ? (base_addr + w_span) : (base_addr - w_span);

    // A base register that is also loaded keeps the loaded value.
    assign w_wb_en = writeback && (w_count != '0) && !(is_load && reg_list[base_reg]);

    assign w_accept = (r_state == c_s_idle) && start;

    // ------------------------------------------------------------------
    // Current register: lowest set bit of the remaining list
    // ------------------------------------------------------------------
    always_comb begin
        w_cur_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (r_remaining[i]) begin
                w_cur_idx = ADDR_WIDTH'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit.
    assign w_rem_next = r_remaining & (r_remaining - NUM_REGS'(1));
    assign w_last     = (w_rem_next == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_remaining  <= '0;
            r_addr       <= '0;
            r_final_addr <= '0;
            r_is_load    <= 1'b0;
            r_wb_en      <= 1'b0;
            r_base_reg   <= '0;
        end else if (w_accept) begin
            r_remaining  <= reg_list;
            r_addr       <= w_start_addr;
            r_final_addr <= w_final_addr;
            r_is_load    <= is_load;
            r_wb_en      <= w_wb_en;
            r_base_reg   <= base_reg;
        end else if ((r_state == c_s_xfer) && mem_ready) begin
            r_remaining  <= w_rem_next;
            r_addr       <= r_addr + c_four;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != c_s_idle);
        done         = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        read_rm      = '0;
        rd_we        = 1'b0;
        write_rd     = '0;
        rd_in        = '0;
        pc_we        = 1'b0;
        pc_in        = '0;

        case (r_state)
            c_s_idle: begin
                if (start) begin
                    w_next_state = (reg_list != '0) ? c_s_xfer : c_s_done;
                end
            end
            c_s_xfer: begin
                mem_req  = 1'b1;
                mem_we   = !r_is_load;
                mem_addr = r_addr;
                if (!r_is_load) begin
                    read_rm   = w_cur_idx;
                    mem_wdata = rm_data;
                end else if (mem_ready) begin
                    if (w_cur_idx == c_pc_idx) begin
                        pc_we = 1'b1;
                        pc_in = mem_rdata & ~WORD_SIZE'(3);
                    end else begin
                        rd_we    = 1'b1;
                        write_rd = w_cur_idx;
                        rd_in    = mem_rdata;
                    end
                end
                if (mem_ready) begin
                    w_next_state = w_last ? c_s_wb : c_s_xfer;
                end
            end
            c_s_wb: begin
                if (r_wb_en) begin
                    rd_we    = 1'b1;
                    write_rd = r_base_reg;
                    rd_in    = r_final_addr;
                end
                w_next_state = c_s_done;
            end
            default: begin
                done         = 1'b1;
                w_next_state = c_s_idle;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/block_transfer_sequencer.md
# block_transfer_sequencer

Multi-cycle sequencer for ARM block data transfers (LDM/STM). It sits between decode and the register file, and walks a 16-bit register list one register per memory beat. For stores it drives the register file read port (rm); for loads it drives the write port (rd) and the PC write port. It also performs optional base-register writeback. While it runs, it holds `busy` high so the core stalls fetch and PC increment.

## Interface
- WORD_SIZE, 32, data/address width
- NUM_REGS, 16, register count; also the width of the register list
- ADDR_WIDTH, 4, register index width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
- start  in  1  one-cycle request; sampled only in IDLE
- is_load  in  1  1 = LDM, 0 = STM
- up  in  1  1 = increment addressing, 0 = decrement
- pre  in  1  1 = before (IB/DB), 0 = after (IA/DA)
- writeback  in  1  write the final address to the base register
- base_reg  in  ADDR_WIDTH  base register index
- base_addr  in  WORD_SIZE  base register value, captured at start
- reg_list  in  NUM_REGS  register list, captured at start
- mem_ready  in  1  memory completes the current beat this cycle
- mem_rdata  in  WORD_SIZE  load data, valid when mem_ready=1
- rm_data  in  WORD_SIZE  register file rm_out
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse in the DONE state
- mem_req, mem_we  out  1  beat request; write enable (=!is_load while mem_req)
- mem_addr, mem_wdata  out  WORD_SIZE  beat address; store data (=rm_data)
- read_rm  out  ADDR_WIDTH  register index currently being stored
- rd_we, write_rd, rd_in  out  1/ADDR_WIDTH/WORD_SIZE  register file write port
- pc_we, pc_in  out  1/WORD_SIZE  register file PC write port

## Operation
- States: IDLE, XFER, WB, DONE.
  - IDLE→XFER on start with a nonzero reg_list.
  - IDLE→DONE on start with reg_list=0. No memory beats, no writes.
  - XFER→XFER on mem_ready while bits remain.
  - XFER→WB on mem_ready for the last bit.
  - WB→DONE, then DONE→IDLE, unconditionally.
- Capture at start:
  - The list goes into a `remaining` register. N = popcount(reg_list), computed as a 0..16 value.
  - The address counter is loaded per the start-address list below.
  - The final address is base_addr+4N when up=1, base_addr−4N when up=0. All address arithmetic is modulo 2^WORD_SIZE.
- Start address, by mode:
  - IA: base.
  - IB: base+4.
  - DA: base−4N+4.
  - DB: base−4N.
- Transfer order: registers always go lowest index first, at ascending addresses. The current register is the lowest set bit of `remaining`.
- On a mem_ready beat:
  - Clear that bit in `remaining`.
  - Add 4 to the address.
- Load beat, combinational in the mem_ready cycle:
  - Current register ≠ 15: rd_we=1, write_rd=current register, rd_in=mem_rdata.
  - Current register = 15: pc_we=1, pc_in=mem_rdata&~3, and rd_we=0.
- Store beat: read_rm=current register and mem_wdata=rm_data, held for the whole beat.
- WB state: rd_we=1, write_rd=base_reg, rd_in=final address, but only when all of the following hold:
  - writeback=1;
  - N≠0;
  - not (is_load and reg_list[base_reg]=1). A loaded base wins and writeback is suppressed.
- A start that arrives outside IDLE is ignored; no queueing.

## Timing
- Reset values: busy=0, done=0, mem_req=0, mem_we=0, rd_we=0, pc_we=0. All address, data and index outputs are 0, and the state is IDLE.
- Cycle 0 is the start cycle. From cycle 1, mem_req=1 with the first address.
- mem_req, mem_addr, mem_we and mem_wdata stay stable until the beat ends with mem_ready=1. The next beat's address appears the following cycle; there are no idle cycles between beats.
- With zero-wait memory (mem_ready tied to 1):
  - XFER occupies cycles 1..N, WB is cycle N+1, and done=1 in cycle N+2.
  - An empty list gives done in cycle 1.
- Each wait cycle (mem_req=1, mem_ready=0) adds one cycle to the total latency.
- mem_ready is ignored outside XFER.
- rd_we and pc_we are never asserted outside XFER (loads) or WB (base writeback). They are at most one cycle per beat.
- Reset mid-transfer: all outputs drop asynchronously, and the remaining beats and writeback are abandoned.

## Test plan
- STM IA, base=0x100, list=0x000E, writeback=1, base_reg=0, zero-wait:
  - beats r1@0x100, r2@0x104, r3@0x108 with mem_we=1;
  - WB writes r0=0x10C;
  - done in cycle 5.
- LDM DB, base=0x200, list=0x8003:
  - loads r0@0x1F4, r1@0x1F8;
  - PC loaded from 0x1FC via pc_we, with pc_in bits[1:0]=0.
- LDM IA, base_reg=2, list=0x0006, writeback=1: r2 takes the loaded data and WB asserts no rd_we.
- Empty list start: no mem_req, no writes, done in cycle 1. A start held high during busy is not re-accepted.
- Two wait cycles on beat 1 of a 2-register STM IB at base 0xFFFFFFFC:
  - address wraps to 0x0 then 0x4;
  - mem signals are stable across the waits;
  - done is 2 cycles later than in the zero-wait case.
- reset=0 asserted in the middle of the 3rd beat: busy and mem_req are 0 immediately, there are no further rd_we pulses, and after release a new start proceeds normally.
